// File: rtl/sprite_pixel_compositor_pkg.sv
// Shared parameters and types for the sprite pixel compositor.
// Palette index layout: bit 2 selects the background half of the palette.
package sprite_pkg;
   localparam int NUM_SPRITES = 8;
   localparam int SPRITE_W    = 16;
   localparam int HCOUNT_W    = 11;
   localparam int H_ACTIVE    = 640;
   localparam int PAL_N       = 8;

   typedef logic [23:0] color_t;
   typedef logic [1:0]  pix_t;
   typedef logic [2:0]  pal_idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } spr_state_t;

   function automatic pal_idx_t pal_index(input logic is_bg, input pix_t px);
      return {is_bg, px};
   endfunction
endpackage

// File: rtl/sprite_window.sv
// One sprite lane: fires once per line at its X column and enables its shift register
// for SPRITE_W pixels or until the right edge of the visible area, whichever comes first.
module sprite_window
   import sprite_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_line_start,
   input  logic [HCOUNT_W-1:0] i_hcount,
   input  logic [HCOUNT_W-1:0] i_sprite_x,
   input  logic                i_sprite_on,
   output logic                o_shift_en,
   output logic                o_valid
);
   localparam logic [HCOUNT_W-1:0] H_END    = HCOUNT_W'(H_ACTIVE);
   localparam logic [3:0]          LAST_CNT = 4'(SPRITE_W - 2);

   spr_state_t r_state;
   logic [3:0] r_cnt;
   logic       r_valid;
   logic       w_visible;
   logic       w_start;

   assign w_visible = (i_hcount < H_END);
   // line_start re-arms the lane and suppresses a start in the same cycle
   assign w_start   = i_reset && !i_line_start && (r_state == IDLE) && i_sprite_on &&
                      (i_hcount == i_sprite_x) && w_visible;
   assign o_shift_en = w_start || (i_reset && (r_state == ACTIVE) && w_visible);
   assign o_valid    = r_valid;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= o_shift_en;
         if (i_line_start) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
         end else begin
            // r_cnt counts ACTIVE pulses; the start column supplies the first one
            case (r_state)
               IDLE: begin
                  if (w_start) begin
                     r_state <= ACTIVE;
                     r_cnt   <= 4'd0;
                  end
               end
               ACTIVE: begin
                  if (!w_visible || (r_cnt == LAST_CNT)) begin
                     r_state <= DONE;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               DONE: begin
                  r_state <= DONE;
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= 4'd0;
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/sprite_pixel_compositor.sv
// Sprite/background compositor: lane enables, sprite-over-background priority,
// palette lookup and a fixed two-cycle registered RGB output.
module sprite_pixel_compositor
   import sprite_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_line_start,
   input  logic [HCOUNT_W-1:0]      i_hcount,
   input  logic [HCOUNT_W-1:0]      i_sprite_x [NUM_SPRITES-1:0],
   input  logic [NUM_SPRITES-1:0]   i_sprite_on,
   input  logic [2*NUM_SPRITES-1:0] i_sprite_px,
   input  logic [1:0]               i_bg_px,
   output logic [NUM_SPRITES:0]     o_shift_en,
   input  logic                     i_pal_we,
   input  logic [2:0]               i_pal_addr,
   input  logic [23:0]              i_pal_data,
   output logic [23:0]              o_rgb,
   output logic                     o_rgb_valid
);
   localparam logic [HCOUNT_W-1:0] H_END = HCOUNT_W'(H_ACTIVE);

   logic [NUM_SPRITES-1:0] w_spr_en;
   logic [NUM_SPRITES-1:0] w_spr_valid;
   logic                   w_bg_en;
   logic                   r_bg_valid;
   pal_idx_t               w_idx;
   color_t                 r_pal [PAL_N];
   color_t                 r_rgb;
   logic                   r_rgb_valid;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_win
      sprite_window u_win (
         .i_clk        (i_clk),
         .i_reset      (i_reset),
         .i_line_start (i_line_start),
         .i_hcount     (i_hcount),
         .i_sprite_x   (i_sprite_x[g]),
         .i_sprite_on  (i_sprite_on[g]),
         .o_shift_en   (w_spr_en[g]),
         .o_valid      (w_spr_valid[g])
      );
   end

   assign w_bg_en     = i_reset && (i_hcount < H_END);
   assign o_shift_en  = {w_bg_en, w_spr_en};
   assign o_rgb       = r_rgb;
   assign o_rgb_valid = r_rgb_valid;

   // Scan from the highest lane down so the lowest opaque sprite overwrites the rest
   always_comb begin
      w_idx = pal_index(1'b1, i_bg_px);
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_spr_valid[i] && (i_sprite_px[2*i +: 2] != 2'b00)) begin
            w_idx = pal_index(1'b0, i_sprite_px[2*i +: 2]);
         end else begin
            w_idx = w_idx;
         end
      end
   end

   // The palette read uses the pre-write contents, so a write shows up one column later
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int k = 0; k < PAL_N; k++) begin
            r_pal[k] <= 24'h000000;
         end
         r_bg_valid  <= 1'b0;
         r_rgb       <= 24'h000000;
         r_rgb_valid <= 1'b0;
      end else begin
         if (i_pal_we) begin
            r_pal[i_pal_addr] <= i_pal_data;
         end
         r_bg_valid  <= w_bg_en;
         r_rgb_valid <= r_bg_valid;
         r_rgb       <= r_bg_valid ? r_pal[w_idx] : 24'h000000;
      end
   end
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Bench for sprite_pixel_compositor: directed table, hand sequences and randomized lines
// checked against a window/priority reference model.
module tb_sprite_pixel_compositor;
   import sprite_pkg::*;

   localparam int H_TOTAL = 700;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ls;
   logic [10:0] hc;
   logic [10:0] spx [NUM_SPRITES-1:0];
   logic [7:0]  son;
   logic [15:0] px;
   logic [1:0]  bg;
   logic [8:0]  sen;
   logic        we;
   logic [2:0]  waddr;
   logic [23:0] wdata;
   logic [23:0] rgb;
   logic        rv;

   always #5 clk = ~clk;

   sprite_pixel_compositor dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_line_start (ls),
      .i_hcount     (hc),
      .i_sprite_x   (spx),
      .i_sprite_on  (son),
      .i_sprite_px  (px),
      .i_bg_px      (bg),
      .o_shift_en   (sen),
      .i_pal_we     (we),
      .i_pal_addr   (waddr),
      .i_pal_data   (wdata),
      .o_rgb        (rgb),
      .o_rgb_valid  (rv)
   );

   int          checks = 0;
   int          errors = 0;
   logic [23:0] pal_m [8];
   logic [8:0]  prev_en;
   logic [10:0] prev_hc;
   logic [23:0] rgb_at [H_TOTAL];
   int          pulses [9];
   bit          model_on;

   typedef struct {
      logic [7:0]  on;
      logic [10:0] x;
      logic [15:0] p;
      logic [1:0]  b;
      int          probe;
      logic [23:0] rgb;
   } vec_t;
   vec_t tv [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Lane enabled iff the column lies inside the sprite's visible window
   function automatic logic [8:0] model_en();
      logic [8:0] e = 9'd0;
      if (rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (son[i] && int'(hc) >= int'(spx[i]) && int'(hc) < int'(spx[i]) + SPRITE_W &&
                int'(hc) < H_ACTIVE)
               e[i] = 1'b1;
         end
         e[8] = (int'(hc) < H_ACTIVE);
      end
      return e;
   endfunction

   function automatic logic [23:0] model_rgb(input logic [8:0] en, input logic [15:0] p,
                                             input logic [1:0] b);
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (en[i] && p[2*i +: 2] != 2'b00) return pal_m[{1'b0, p[2*i +: 2]}];
      end
      return pal_m[{1'b1, b}];
   endfunction

   task automatic tick();
      logic [8:0]  en;
      logic [23:0] nrgb;
      logic        nv;
      #1;
      en = model_en();
      if (model_on) chk("shift_en", 32'(sen), 32'(en));
      for (int i = 0; i < 9; i++) pulses[i] += int'(sen[i]);
      nv   = prev_en[8];
      nrgb = nv ? model_rgb(prev_en, px, bg) : 24'h0;
      if (we) pal_m[waddr] = wdata;
      if (!rst_n) begin
         nv = 1'b0;
         nrgb = 24'h0;
         for (int k = 0; k < 8; k++) pal_m[k] = 24'h0;
      end
      @(posedge clk);
      #1;
      if (model_on) begin
         chk("rgb", 32'(rgb), 32'(nrgb));
         chk("rgb_valid", 32'(rv), 32'(nv));
      end
      if (nv) rgb_at[prev_hc] = rgb;
      prev_en = en;
      prev_hc = hc;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      ls = 1'b0;
      we = 1'b0;
      hc = 11'd700;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   task automatic pal_write(input logic [2:0] a, input logic [23:0] d);
      hc = 11'd700;
      we = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic run_line(input bit rnd, input int wr_col, input logic [2:0] wa,
                           input logic [23:0] wd);
      int xi;
      int ex;
      for (int i = 0; i < 9; i++) pulses[i] = 0;
      ls = 1'b1;
      we = 1'b0;
      hc = 11'(H_TOTAL - 1);
      tick();
      ls = 1'b0;
      for (int h = 0; h < H_TOTAL; h++) begin
         hc = 11'(h);
         if (rnd) begin
            px    = 16'($urandom);
            bg    = 2'($urandom);
            we    = ($urandom_range(0, 19) == 0);
            waddr = 3'($urandom);
            wdata = 24'($urandom);
         end else begin
            we    = (h == wr_col);
            waddr = wa;
            wdata = wd;
         end
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         xi = int'(spx[i]);
         ex = (son[i] && xi < H_ACTIVE) ?
              ((H_ACTIVE - xi < SPRITE_W) ? H_ACTIVE - xi : SPRITE_W) : 0;
         chk("lane_pulses", 32'(pulses[i]), 32'(ex));
      end
      chk("bg_pulses", 32'(pulses[8]), 32'(H_ACTIVE));
   endtask

   task automatic probe_en(input int lane, input logic req, input string name);
      #1;
      chk(name, 32'(sen[lane]), 32'(req));
   endtask

   initial begin
      model_on = 1'b1;
      prev_en = 9'd0;
      prev_hc = 11'd0;
      son = 8'h00;
      px = 16'h0000;
      bg = 2'b00;
      waddr = 3'd0;
      wdata = 24'h0;
      for (int i = 0; i < NUM_SPRITES; i++) spx[i] = 11'd700;
      for (int k = 0; k < 8; k++) pal_m[k] = 24'h0;
      for (int h = 0; h < H_TOTAL; h++) rgb_at[h] = 24'h0;

      do_reset(3);
      chk("reset_rgb", 32'(rgb), 32'h0);
      chk("reset_valid", 32'(rv), 32'h0);
      chk("reset_spr_en", 32'(sen[7:0]), 32'h0);

      // Zeroed palette: everything composites to black
      son = 8'hFF;
      for (int i = 0; i < NUM_SPRITES; i++) spx[i] = 11'(i * 80);
      px = 16'hFFFF;
      bg = 2'b11;
      run_line(1'b0, -1, 3'd0, 24'h0);
      chk("zero_pal_rgb", 32'(rgb_at[300]), 32'h0);

      pal_write(3'd1, 24'hFF0000);
      pal_write(3'd2, 24'h00FF00);
      pal_write(3'd3, 24'h0000FF);
      pal_write(3'd4, 24'h111111);
      pal_write(3'd5, 24'h222222);
      pal_write(3'd6, 24'h333333);
      pal_write(3'd7, 24'h444444);

      tv[0] = '{8'h01, 11'd100, 16'h0001, 2'd0, 100, 24'hFF0000};
      tv[1] = '{8'h01, 11'd100, 16'h0001, 2'd0, 115, 24'hFF0000};
      tv[2] = '{8'h01, 11'd100, 16'h0001, 2'd0, 116, 24'h111111};
      tv[3] = '{8'h24, 11'd200, 16'h0820, 2'd0, 200, 24'h00FF00};
      tv[4] = '{8'h24, 11'd200, 16'h0C00, 2'd0, 205, 24'h0000FF};
      tv[5] = '{8'h24, 11'd200, 16'h0000, 2'd2, 200, 24'h333333};
      tv[6] = '{8'h01, 11'd630, 16'h0003, 2'd0, 639, 24'h0000FF};
      tv[7] = '{8'h01, 11'd100, 16'h0001, 2'd1,  99, 24'h222222};
      tv[8] = '{8'h00, 11'd100, 16'h0001, 2'd3, 100, 24'h444444};
      tv[9] = '{8'h01, 11'd640, 16'h0001, 2'd0, 639, 24'h111111};
      for (int r = 0; r < 10; r++) begin
         son = tv[r].on;
         for (int i = 0; i < NUM_SPRITES; i++) spx[i] = tv[r].on[i] ? tv[r].x : 11'd700;
         px = tv[r].p;
         bg = tv[r].b;
         run_line(1'b0, -1, 3'd0, 24'h0);
         chk("table_rgb", 32'(rgb_at[tv[r].probe]), 32'(tv[r].rgb));
      end

      // Palette write mid-line: the column read in the write cycle still sees the old colour
      son = 8'h00;
      bg = 2'b00;
      run_line(1'b0, 300, 3'd4, 24'h123456);
      chk("pal_old", 32'(rgb_at[299]), 32'h111111);
      chk("pal_new", 32'(rgb_at[300]), 32'h123456);
      chk("pal_new2", 32'(rgb_at[301]), 32'h123456);

      // Hold hcount on the sprite column: fires once per line
      model_on = 1'b0;
      son = 8'h01;
      spx[0] = 11'd100;
      ls = 1'b1;
      hc = 11'd100;
      tick();
      ls = 1'b0;
      for (int i = 0; i < 9; i++) pulses[i] = 0;
      repeat (25) tick();
      chk("hold_pulses", 32'(pulses[0]), 32'd16);
      ls = 1'b1;
      probe_en(0, 1'b0, "en_ls_done");
      tick();
      ls = 1'b0;
      probe_en(0, 1'b1, "en_rearm");
      tick();
      repeat (2) tick();
      ls = 1'b1;
      hc = 11'd101;
      probe_en(0, 1'b1, "en_ls_active");
      tick();
      ls = 1'b0;
      hc = 11'd102;
      probe_en(0, 1'b0, "en_after_ls");
      tick();
      hc = 11'd103;
      probe_en(0, 1'b0, "en_stays_idle");
      tick();

      // Reset in the middle of a line
      do_reset(1);
      pal_write(3'd1, 24'hFF0000);
      son = 8'h01;
      spx[0] = 11'd100;
      px = 16'h0001;
      bg = 2'b00;
      ls = 1'b1;
      hc = 11'd699;
      tick();
      ls = 1'b0;
      for (int h = 0; h <= 105; h++) begin
         hc = 11'(h);
         tick();
      end
      chk("mid_rv_before", 32'(rv), 32'h1);
      chk("mid_rgb_before", 32'(rgb), 32'hFF0000);
      rst_n = 1'b0;
      hc = 11'd106;
      tick();
      rst_n = 1'b1;
      chk("mid_rv_flush", 32'(rv), 32'h0);
      chk("mid_rgb_flush", 32'(rgb), 32'h0);
      for (int i = 0; i < 9; i++) pulses[i] = 0;
      hc = 11'd107;
      probe_en(0, 1'b0, "mid_no_restart");
      tick();
      chk("mid_rv_flush2", 32'(rv), 32'h0);
      hc = 11'd108;
      tick();
      chk("mid_rv_resume", 32'(rv), 32'h1);
      chk("mid_rgb_resume", 32'(rgb), 32'h0);
      for (int h = 109; h < H_TOTAL; h++) begin
         hc = 11'(h);
         tick();
      end
      chk("mid_no_restart_cnt", 32'(pulses[0]), 32'h0);

      // Randomized lines against the reference model
      do_reset(2);
      model_on = 1'b1;
      for (int n = 0; n < 5; n++) begin
         son = 8'($urandom);
         for (int i = 0; i < NUM_SPRITES; i++) spx[i] = 11'($urandom_range(0, 700));
         if (n == 0) spx[3] = 11'd630;
         if (n == 1) spx[3] = 11'd640;
         run_line(1'b1, -1, 3'd0, 24'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
